// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and register-index widths, MEM-stage FSM states,
// and the MEM/WB register payload.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} memstate_t;

  typedef struct packed {
    logic     valid;
    logic     regWEN;
    regbits_t wsel;
    word_t    wdat;
    word_t    pc;
    logic     halt;
  } memwb_t;

  function automatic word_t word_align(input word_t a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/memwb_if.sv
// MEM/WB register boundary: next-state payload plus capture strobe in, latched payload out.
interface memwb_if;
  import cpu_types_pkg::*;
  logic   cap;
  memwb_t d;
  memwb_t q;
  modport latch (input cap, input d, output q);
  modport stage (output cap, output d, input q);
endinterface

// File: rtl/memwb_latch.sv
// MEM/WB pipeline register: captures on cap, otherwise inserts a bubble (valid/regWEN
// cleared, payload held). halt is sticky once captured.
module memwb_latch
  import cpu_types_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  memwb_if.latch mw
);
  memwb_t q_q, q_d;

  always_comb begin
    q_d        = q_q;
    q_d.valid  = 1'b0;
    q_d.regWEN = 1'b0;
    if (mw.cap) begin
      q_d      = mw.d;
      q_d.halt = q_q.halt | mw.d.halt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign mw.q = q_q;
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues word loads/stores to the data cache, stalls until dhit,
// forwards results, and feeds the MEM/WB register. Halt is terminal until reset.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 256
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     ex_valid_i,
  input  logic     ex_regWEN_i,
  input  logic     ex_dREN_i,
  input  logic     ex_dWEN_i,
  input  logic     ex_halt_i,
  input  regbits_t ex_wsel_i,
  input  word_t    ex_aluresult_i,
  input  word_t    ex_rdat2_i,
  input  word_t    ex_pc_i,
  input  logic     dhit_i,
  input  word_t    dmemload_i,
  output logic     dmemREN_o,
  output logic     dmemWEN_o,
  output word_t    dmemaddr_o,
  output word_t    dmemstore_o,
  output logic     mem_stall_o,
  output logic     fwd_valid_o,
  output regbits_t fwd_wsel_o,
  output word_t    fwd_wdat_o,
  output logic     wb_valid_o,
  output logic     wb_regWEN_o,
  output regbits_t wb_wsel_o,
  output word_t    wb_wdat_o,
  output word_t    wb_pc_o,
  output logic     wb_halt_o,
  output logic     mem_misalign_o,
  output logic     mem_timeout_o
);
  localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

  memstate_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        halted, acc, is_store, regwen;
  word_t       wdat;

  assign halted   = (state_q == HALTED);
  // Reset gates the request combinationally so an in-flight access is dropped at once.
  assign acc      = ~rst_i & ex_valid_i & (ex_dREN_i | ex_dWEN_i) & ~halted;
  assign is_store = ex_dWEN_i & ~ex_dREN_i;
  assign regwen   = ex_regWEN_i & ~is_store;
  assign wdat     = ex_dREN_i ? dmemload_i : ex_aluresult_i;

  assign dmemREN_o      = acc & ex_dREN_i;
  assign dmemWEN_o      = acc & is_store;
  assign dmemaddr_o     = word_align(ex_aluresult_i);
  assign dmemstore_o    = ex_rdat2_i;
  assign mem_stall_o    = acc & ~dhit_i;
  assign mem_misalign_o = acc & dhit_i & (ex_aluresult_i[1:0] != 2'b00);
  assign mem_timeout_o  = timeout_q;

  assign fwd_valid_o = ex_valid_i & regwen & (ex_wsel_i != '0) & ~mem_stall_o & ~halted;
  assign fwd_wsel_o  = ex_wsel_i;
  assign fwd_wdat_o  = wdat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (acc && !dhit_i) begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (!acc || dhit_i) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
          if (cnt_d >= MAX_W) timeout_d = 1'b1;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
    // A halt only retires once any access it shares the slot with has completed.
    if (!halted && ex_valid_i && ex_halt_i && !mem_stall_o) state_d = HALTED;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  memwb_if mw ();

  assign mw.cap = ex_valid_i & ~mem_stall_o & ~halted;
  always_comb begin
    mw.d        = '0;
    mw.d.valid  = 1'b1;
    mw.d.regWEN = regwen;
    mw.d.wsel   = ex_wsel_i;
    mw.d.wdat   = wdat;
    mw.d.pc     = ex_pc_i;
    mw.d.halt   = ex_halt_i;
  end

  memwb_latch u_memwb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .mw    (mw.latch)
  );

  assign wb_valid_o  = mw.q.valid;
  assign wb_regWEN_o = mw.q.regWEN;
  assign wb_wsel_o   = mw.q.wsel;
  assign wb_wdat_o   = mw.q.wdat;
  assign wb_pc_o     = mw.q.pc;
  assign wb_halt_o   = mw.q.halt;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB records into a queue,
// a negedge monitor pops and compares whenever wb_valid is presented.
module tb_mem_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_valid, ex_regWEN, ex_dREN, ex_dWEN, ex_halt, dhit;
  logic [4:0]  ex_wsel;
  logic [31:0] ex_alu, ex_rdat2, ex_pc, dmemload;
  logic        dmemREN, dmemWEN, mem_stall, fwd_valid, wb_valid, wb_regWEN, wb_halt;
  logic        mem_misalign, mem_timeout;
  logic [31:0] dmemaddr, dmemstore, fwd_wdat, wb_wdat, wb_pc;
  logic [4:0]  fwd_wsel, wb_wsel;

  int checks = 0, failures = 0;

  typedef struct {
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        regwen;
    logic [31:0] pc;
    logic        halt;
  } exp_t;
  exp_t sb[$];

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_regWEN_i(ex_regWEN), .ex_dREN_i(ex_dREN),
    .ex_dWEN_i(ex_dWEN), .ex_halt_i(ex_halt), .ex_wsel_i(ex_wsel),
    .ex_aluresult_i(ex_alu), .ex_rdat2_i(ex_rdat2), .ex_pc_i(ex_pc),
    .dhit_i(dhit), .dmemload_i(dmemload),
    .dmemREN_o(dmemREN), .dmemWEN_o(dmemWEN), .dmemaddr_o(dmemaddr),
    .dmemstore_o(dmemstore), .mem_stall_o(mem_stall), .fwd_valid_o(fwd_valid),
    .fwd_wsel_o(fwd_wsel), .fwd_wdat_o(fwd_wdat), .wb_valid_o(wb_valid),
    .wb_regWEN_o(wb_regWEN), .wb_wsel_o(wb_wsel), .wb_wdat_o(wb_wdat),
    .wb_pc_o(wb_pc), .wb_halt_o(wb_halt), .mem_misalign_o(mem_misalign),
    .mem_timeout_o(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic rw, input logic rd, input logic wr,
                       input logic h, input logic [4:0] ws, input logic [31:0] alu,
                       input logic [31:0] r2, input logic [31:0] pc);
    ex_valid = v; ex_regWEN = rw; ex_dREN = rd; ex_dWEN = wr; ex_halt = h;
    ex_wsel = ws; ex_alu = alu; ex_rdat2 = r2; ex_pc = pc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dhit = 1'b0;
  endtask

  task automatic push(input logic [4:0] ws, input logic [31:0] wd, input logic rw,
                      input logic [31:0] pc, input logic h);
    exp_t e;
    e.wsel = ws; e.wdat = wd; e.regwen = rw; e.pc = pc; e.halt = h;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_spurious_valid", {31'b0, wb_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("wb_wsel",   {27'b0, wb_wsel},   {27'b0, e.wsel});
        chk("wb_wdat",   wb_wdat,            e.wdat);
        chk("wb_regWEN", {31'b0, wb_regWEN}, {31'b0, e.regwen});
        chk("wb_pc",     wb_pc,              e.pc);
        chk("wb_halt",   {31'b0, wb_halt},   {31'b0, e.halt});
      end
    end
  end

  initial begin
    idle();
    dmemload = 32'h0;
    smp();
    chk("rst_wb_valid", {31'b0, wb_valid},    32'h0);
    chk("rst_wb_halt",  {31'b0, wb_halt},     32'h0);
    chk("rst_timeout",  {31'b0, mem_timeout}, 32'h0);
    chk("rst_wb_pc",    wb_pc,                32'h0);
    nxt();
    rst = 1'b0;
    nxt();

    // ALU op: no access, forwards immediately, lands in WB next edge
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h40);
    push(5'd5, 32'h1234, 1'b1, 32'h40, 1'b0);
    smp();
    chk("alu_stall",     {31'b0, mem_stall}, 32'h0);
    chk("alu_fwd_valid", {31'b0, fwd_valid}, 32'h1);
    chk("alu_fwd_wdat",  fwd_wdat,           32'h1234);
    chk("alu_fwd_wsel",  {27'b0, fwd_wsel},  32'h5);
    nxt(); idle(); nxt();

    // Load 0x100, three stall cycles then hit
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h100, 32'h0, 32'h44);
    push(5'd7, 32'hDEADBEEF, 1'b1, 32'h44, 1'b0);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("ld_stall",     {31'b0, mem_stall}, 32'h1);
      chk("ld_dmemREN",   {31'b0, dmemREN},   32'h1);
      chk("ld_wb_bubble", {31'b0, wb_valid},  32'h0);
      chk("ld_fwd_hold",  {31'b0, fwd_valid}, 32'h0);
      nxt();
    end
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    smp();
    chk("ld_hit_stall", {31'b0, mem_stall},   32'h0);
    chk("ld_dmemaddr",  dmemaddr,             32'h100);
    chk("ld_fwd_wdat",  fwd_wdat,             32'hDEADBEEF);
    chk("ld_timeout",   {31'b0, mem_timeout}, 32'h0);
    nxt(); idle(); nxt();

    // Misaligned store, zero-latency hit
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h203, 32'hCAFE, 32'h48);
    dhit = 1'b1;
    push(5'd9, 32'h203, 1'b0, 32'h48, 1'b0);
    smp();
    chk("st_dmemaddr",  dmemaddr,              32'h200);
    chk("st_dmemWEN",   {31'b0, dmemWEN},      32'h1);
    chk("st_dmemREN",   {31'b0, dmemREN},      32'h0);
    chk("st_dmemstore", dmemstore,             32'hCAFE);
    chk("st_stall",     {31'b0, mem_stall},    32'h0);
    chk("st_misalign",  {31'b0, mem_misalign}, 32'h1);
    chk("st_fwd_valid", {31'b0, fwd_valid},    32'h0);
    nxt(); idle();
    smp();
    chk("st_misalign_pulse", {31'b0, mem_misalign}, 32'h0);
    nxt();

    // Timeout: MAX_WAIT=4, dhit withheld six cycles
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h300, 32'h0, 32'h50);
    push(5'd3, 32'h55AA1234, 1'b1, 32'h50, 1'b0);
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("to_stall",   {31'b0, mem_stall},   32'h1);
      chk("to_timeout", {31'b0, mem_timeout}, (i >= 5) ? 32'h1 : 32'h0);
      nxt();
    end
    dhit = 1'b1; dmemload = 32'h55AA1234;
    smp();
    chk("to_hit_stall", {31'b0, mem_stall}, 32'h0);
    nxt(); idle();
    smp();
    chk("to_sticky", {31'b0, mem_timeout}, 32'h1);
    nxt();

    // dhit with no request is ignored
    dhit = 1'b1; ex_alu = 32'h3;
    smp();
    chk("nohit_ren",      {31'b0, dmemREN},      32'h0);
    chk("nohit_stall",    {31'b0, mem_stall},    32'h0);
    chk("nohit_misalign", {31'b0, mem_misalign}, 32'h0);
    nxt(); idle(); nxt();

    // Load pending then halt: load retires first, halt sticky, later loads blocked
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h400, 32'h0, 32'h58);
    push(5'd4, 32'h0BADF00D, 1'b1, 32'h58, 1'b0);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("hl_ld_stall", {31'b0, mem_stall}, 32'h1);
      chk("hl_pre_halt", {31'b0, wb_halt},   32'h0);
      nxt();
    end
    dhit = 1'b1; dmemload = 32'h0BADF00D;
    smp();
    chk("hl_ld_hit", {31'b0, mem_stall}, 32'h0);
    nxt();
    dhit = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h60);
    push(5'd0, 32'h0, 1'b0, 32'h60, 1'b1);
    smp();
    chk("hl_not_yet", {31'b0, wb_halt}, 32'h0);
    nxt();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h500, 32'h0, 32'h64);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("hl_ren_blocked", {31'b0, dmemREN},   32'h0);
      chk("hl_no_stall",    {31'b0, mem_stall}, 32'h0);
      chk("hl_sticky",      {31'b0, wb_halt},   32'h1);
      if (i > 0) chk("hl_wb_valid", {31'b0, wb_valid}, 32'h0);
      nxt();
    end

    // Reset clears halt and timeout
    idle();
    rst = 1'b1;
    smp();
    chk("rst2_halt",    {31'b0, wb_halt},     32'h0);
    chk("rst2_timeout", {31'b0, mem_timeout}, 32'h0);
    nxt();
    rst = 1'b0;
    nxt();

    // Reset in the middle of an ACCESS
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h11, 32'hABCD, 32'h0, 32'h70);
    push(5'h11, 32'hABCD, 1'b1, 32'h70, 1'b0);
    nxt();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h600, 32'h0, 32'h74);
    smp();
    chk("ra_issue_stall", {31'b0, mem_stall}, 32'h1);
    nxt();
    #2;
    chk("ra_pre_ren",  {31'b0, dmemREN}, 32'h1);
    chk("ra_pre_wsel", {27'b0, wb_wsel}, 32'h11);
    rst = 1'b1;
    #1;
    chk("ra_ren",    {31'b0, dmemREN},   32'h0);
    chk("ra_stall",  {31'b0, mem_stall}, 32'h0);
    chk("ra_valid",  {31'b0, wb_valid},  32'h0);
    chk("ra_regWEN", {31'b0, wb_regWEN}, 32'h0);
    chk("ra_wsel",   {27'b0, wb_wsel},   32'h0);
    chk("ra_wdat",   wb_wdat,            32'h0);
    chk("ra_pc",     wb_pc,              32'h0);
    idle();
    nxt();
    rst = 1'b0;
    nxt();
    smp();
    chk("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
